// File: rtl/lvds_cnt_pattern_chk.sv
// Counter-pattern checker for the LVDS loopback lanes: acquires lock on a +1 sequence,
// then counts word/bit errors, lock losses and per-window word errors.
module lvds_cnt_pattern_chk #(
  parameter int W          = 5,
  parameter int CNT_W      = 32,
  parameter int LOCK_THR   = 8,
  parameter int LOSS_THR   = 4,
  parameter int WIN_CYCLES = 250000000
) (
  input  logic             CLK_250M,
  input  logic             RST,
  input  logic             CLR,
  input  logic             DIN_VLD,
  input  logic [W-1:0]     DIN,
  output logic             LOCKED,
  output logic [CNT_W-1:0] ERR_WORD_CNT,
  output logic [CNT_W-1:0] ERR_BIT_CNT,
  output logic [15:0]      LOCK_LOSS_CNT,
  output logic [CNT_W-1:0] WIN_ERR_LATCH,
  output logic             WIN_DONE
);

  localparam int MW = $clog2(LOCK_THR + 1);
  localparam int SW = $clog2(LOSS_THR + 1);
  localparam int WW = $clog2(WIN_CYCLES + 1);
  localparam int PW = $clog2(W + 1);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [MW-1:0] LOCK_THR_C = MW'(LOCK_THR);
  localparam logic [SW-1:0] LOSS_THR_C = SW'(LOSS_THR);
  localparam logic [WW-1:0] WIN_LAST_C = WW'(WIN_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [W-1:0]     exp_q, exp_d;
  logic [MW-1:0]    match_q, match_d;
  logic [SW-1:0]    miss_q, miss_d;
  logic [CNT_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [15:0]      loss_q, loss_d;
  logic [WW-1:0]    win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] win_err_q, win_err_d;
  logic [CNT_W-1:0] latch_q, latch_d;
  logic             done_q, done_d;

  logic [W-1:0]     diff;
  logic [PW-1:0]    pop;
  logic [MW-1:0]    match_inc;
  logic             err_hit;
  logic [CNT_W-1:0] win_err_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    diff      = DIN ^ exp_q;
    pop       = '0;
    for (int i = 0; i < W; i++) begin
      pop = pop + PW'(diff[i]);
    end
    state_d   = state_q;
    exp_d     = exp_q;
    match_d   = match_q;
    miss_d    = miss_q;
    word_d    = word_q;
    bit_d     = bit_q;
    loss_d    = loss_q;
    match_inc = '0;
    err_hit   = 1'b0;

    if (DIN_VLD) begin
      if (state_q == ST_SEARCH) begin
        // Search resyncs to the incoming word; a match only extends an existing run.
        exp_d     = DIN + W'(1);
        match_inc = (diff == '0 && match_q != '0) ? match_q + MW'(1) : MW'(1);
        match_d   = match_inc;
        if (match_inc == LOCK_THR_C) begin
          state_d = ST_LOCKED;
          miss_d  = '0;
        end
      end else begin
        exp_d = exp_q + W'(1);
        if (diff == '0) begin
          miss_d = '0;
        end else begin
          err_hit = 1'b1;
          word_d  = sat_add(word_q, CNT_W'(1));
          bit_d   = sat_add(bit_q, CNT_W'(pop));
          miss_d  = miss_q + SW'(1);
          if (miss_q + SW'(1) == LOSS_THR_C) begin
            state_d = ST_SEARCH;
            match_d = '0;
            loss_d  = (loss_q == 16'hFFFF) ? loss_q : loss_q + 16'd1;
          end
        end
      end
    end

    if (CLR) begin
      word_d = '0;
      bit_d  = '0;
      loss_d = '0;
    end

    // The error on the last window cycle still belongs to the closing window.
    win_err_inc = err_hit ? sat_add(win_err_q, CNT_W'(1)) : win_err_q;
    latch_d     = latch_q;
    if (win_cnt_q == WIN_LAST_C) begin
      win_cnt_d = '0;
      win_err_d = '0;
      latch_d   = win_err_inc;
      done_d    = 1'b1;
    end else begin
      win_cnt_d = win_cnt_q + WW'(1);
      win_err_d = win_err_inc;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK_250M or posedge RST) begin
    if (RST) begin
      state_q   <= ST_SEARCH;
      exp_q     <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      word_q    <= '0;
      bit_q     <= '0;
      loss_q    <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      latch_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      word_q    <= word_d;
      bit_q     <= bit_d;
      loss_q    <= loss_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      latch_q   <= latch_d;
      done_q    <= done_d;
    end
  end

  assign LOCKED        = (state_q == ST_LOCKED);
  assign ERR_WORD_CNT  = word_q;
  assign ERR_BIT_CNT   = bit_q;
  assign LOCK_LOSS_CNT = loss_q;
  assign WIN_ERR_LATCH = latch_q;
  assign WIN_DONE      = done_q;

endmodule
